// File: rtl/serial_deserializer.sv
// serial_deserializer
// Collects enabled serial bits into WIDTH-bit words and hands each completed
// word to a single-entry valid/ready output register. SOF re-aligns the word
// boundary to the current bit. A completion that finds the output register
// still occupied (and not being drained) is dropped and latches OVF until reset.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D,
    input  logic             E,
    input  logic             SOF,
    input  logic             Q_ready,
    output logic [WIDTH-1:0] Q,
    output logic             Q_valid,
    output logic             OVF
);

    // Counter is at least one bit wide so WIDTH=1 still elaborates cleanly.
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Shift register and bit counter.
    logic [WIDTH-1:0] sreg_reg;
    logic [WIDTH-1:0] sreg_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Output buffer.
    logic [WIDTH-1:0] q_reg;
    logic             q_valid_reg;
    logic             ovf_reg;

    // SOF throws away the partial word, so the shift starts from an empty
    // register and the counter from zero.
    logic [WIDTH-1:0] base_word;
    logic [CNT_W-1:0] cnt_base;
    logic [WIDTH-1:0] shifted_word;

    logic word_done;
    logic buf_load;
    logic buf_drop;
    logic buf_pop;

    assign base_word = SOF ? '0 : sreg_reg;
    assign cnt_base  = SOF ? '0 : cnt_reg;

    // shifted_word is the register contents with the current bit appended;
    // on the last bit of a word it is exactly the completed word.
    genvar gi;
    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted_word = D;
        end else if (MSB_FIRST != 0) begin : g_msb
            // Older bits move towards the MSB; the newest bit enters at bit 0.
            for (gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi == 0) begin : g_in
                    assign shifted_word[gi] = D;
                end else begin : g_mv
                    assign shifted_word[gi] = base_word[gi-1];
                end
            end
        end else begin : g_lsb
            // Older bits move towards the LSB; the newest bit enters at the MSB.
            for (gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi == WIDTH - 1) begin : g_in
                    assign shifted_word[gi] = D;
                end else begin : g_mv
                    assign shifted_word[gi] = base_word[gi+1];
                end
            end
        end
    endgenerate

    // A word completes when an enabled bit fills the last position.
    assign word_done = E && (cnt_base == CNT_LAST);

    // Buffer decisions: a completion loads when the buffer is free or being
    // drained this cycle, otherwise the word is lost and flagged.
    assign buf_pop  = q_valid_reg && Q_ready;
    assign buf_load = word_done && (!q_valid_reg || Q_ready);
    assign buf_drop = word_done && q_valid_reg && !Q_ready;

    // Next-state for the shift register and bit counter; both hold when E=0.
    always_comb begin
        sreg_next = sreg_reg;
        cnt_next  = cnt_reg;
        if (E) begin
            sreg_next = shifted_word;
            if (word_done) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_base + 1'b1;
            end
        end
    end

    // Shift register and bit counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            sreg_reg <= sreg_next;
            cnt_reg  <= cnt_next;
        end
    end

    // Single-entry output register with sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            if (buf_load) begin
                q_reg       <= shifted_word;
                q_valid_reg <= 1'b1;
            end else if (buf_pop) begin
                q_valid_reg <= 1'b0;
            end
            if (buf_drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign Q       = q_reg;
    assign Q_valid = q_valid_reg;
    assign OVF     = ovf_reg;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: three instances (8-bit MSB-first, 8-bit
// LSB-first, 1-bit) share the same inputs. A bit-list reference model tracks
// each one and is compared every cycle; directed sequences add literal checks.
module tb_serial_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst     = 1'b1;
    logic D       = 1'b0;
    logic E       = 1'b0;
    logic SOF     = 1'b0;
    logic Q_ready = 1'b0;

    logic [7:0] q_msb;
    logic [7:0] q_lsb;
    logic [0:0] q_w1;
    logic       v_msb, v_lsb, v_w1;
    logic       o_msb, o_lsb, o_w1;

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .D(D), .E(E), .SOF(SOF), .Q_ready(Q_ready),
        .Q(q_msb), .Q_valid(v_msb), .OVF(o_msb)
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .D(D), .E(E), .SOF(SOF), .Q_ready(Q_ready),
        .Q(q_lsb), .Q_valid(v_lsb), .OVF(o_lsb)
    );

    serial_deserializer #(.WIDTH(1), .MSB_FIRST(1)) dut_w1 (
        .clk(clk), .rst(rst), .D(D), .E(E), .SOF(SOF), .Q_ready(Q_ready),
        .Q(q_w1), .Q_valid(v_w1), .OVF(o_w1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: list of received bits per instance plus buffer state.
    localparam int M_W[3]   = '{8, 8, 1};
    localparam int M_MSB[3] = '{1, 0, 1};
    int         m_nb[3];
    int         m_bits[3][8];
    logic [7:0] m_q[3];
    logic       m_v[3];
    logic       m_ovf[3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit         done;
            logic [7:0] word;
            done = 1'b0;
            word = 8'h00;
            if (rst) begin
                m_nb[k]  = 0;
                m_q[k]   = 8'h00;
                m_v[k]   = 1'b0;
                m_ovf[k] = 1'b0;
            end else begin
                if (E) begin
                    if (SOF) m_nb[k] = 0;
                    m_bits[k][m_nb[k]] = int'(D);
                    m_nb[k]++;
                    if (m_nb[k] == M_W[k]) begin
                        done = 1'b1;
                        for (int i = 0; i < M_W[k]; i++) begin
                            if (M_MSB[k] != 0) word[M_W[k]-1-i] = m_bits[k][i][0];
                            else               word[i]          = m_bits[k][i][0];
                        end
                        m_nb[k] = 0;
                    end
                end
                if (done) begin
                    if (!m_v[k] || Q_ready) begin
                        m_q[k] = word;
                        m_v[k] = 1'b1;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end else if (m_v[k] && Q_ready) begin
                    m_v[k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of all three instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 3; k++) begin
                    logic [7:0] aq;
                    logic       av, ao;
                    case (k)
                        0:       begin aq = q_msb;         av = v_msb; ao = o_msb; end
                        1:       begin aq = q_lsb;         av = v_lsb; ao = o_lsb; end
                        default: begin aq = {7'b0, q_w1};  av = v_w1;  ao = o_w1;  end
                    endcase
                    check($sformatf("cmp%0d_valid", k), {7'b0, av}, {7'b0, m_v[k]});
                    check($sformatf("cmp%0d_ovf", k), {7'b0, ao}, {7'b0, m_ovf[k]});
                    if (m_v[k]) check($sformatf("cmp%0d_q", k), aq, m_q[k]);
                end
                if (v_msb && Q_ready && !rst) $display("xfer msb q=%h", q_msb);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Present inputs for one rising edge, return at the following falling edge.
    task automatic step(input logic d, input logic e, input logic sof, input logic rdy);
        D = d; E = e; SOF = sof; Q_ready = rdy;
        @(negedge clk);
    endtask

    // Send a word, bit 7 of w first.
    task automatic send_word(input logic [7:0] w, input logic rdy);
        for (int i = 7; i >= 0; i--) step(w[i], 1'b1, 1'b0, rdy);
    endtask

    initial begin
        logic [7:0] w;
        // Reset state.
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("rst_q", q_msb, 8'h00);
        check("rst_valid", {7'b0, v_msb}, 8'h00);
        check("rst_ovf", {7'b0, o_msb}, 8'h00);
        check("rst_w1_valid", {7'b0, v_w1}, 8'h00);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: MSB-first assembly of A5, valid for one cycle only.
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) step(w[i], 1, 0, 1);
        check("t1_valid_early", {7'b0, v_msb}, 8'h00);
        step(w[0], 1, 0, 1);
        check("t1_q", q_msb, 8'hA5);
        check("t1_valid", {7'b0, v_msb}, 8'h01);
        check("t1_ovf", {7'b0, o_msb}, 8'h00);
        check("t1_lsb_q", q_lsb, 8'hA5);
        step(0, 0, 0, 1);
        check("t1_valid_drop", {7'b0, v_msb}, 8'h00);

        // 2a: enable toggling every cycle.
        for (int i = 7; i >= 0; i--) begin
            step(w[i], 1, 0, 1);
            if (i != 0) step(0, 0, 0, 1);
        end
        check("t2_gap_q", q_msb, 8'hA5);
        check("t2_gap_valid", {7'b0, v_msb}, 8'h01);
        step(0, 0, 0, 1);

        // 2b: bits 1,0,1,0,0,0,0,0.
        send_word(8'hA0, 1);
        check("t2_lsb_q", q_lsb, 8'h05);
        check("t2_msb_q", q_msb, 8'hA0);
        step(0, 0, 0, 1);

        // 3: SOF realignment.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
        check("t3_no_word_a", {7'b0, v_msb}, 8'h00);
        step(0, 1, 1, 1);
        check("t3_no_word_b", {7'b0, v_msb}, 8'h00);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 1);
        check("t3_no_word_c", {7'b0, v_msb}, 8'h00);
        step(1, 1, 0, 1);
        check("t3_q", q_msb, 8'h7F);
        check("t3_lsb_q", q_lsb, 8'hFE);
        check("t3_ovf", {7'b0, o_msb}, 8'h00);
        step(0, 0, 0, 1);

        // 4: backpressure and overflow.
        send_word(8'h3C, 0);
        check("t4_q_a", q_msb, 8'h3C);
        check("t4_ovf_a", {7'b0, o_msb}, 8'h00);
        send_word(8'hFF, 0);
        check("t4_q_b", q_msb, 8'h3C);
        check("t4_valid_b", {7'b0, v_msb}, 8'h01);
        check("t4_ovf_b", {7'b0, o_msb}, 8'h01);
        step(0, 0, 0, 1);
        check("t4_valid_c", {7'b0, v_msb}, 8'h00);
        check("t4_ovf_c", {7'b0, o_msb}, 8'h01);

        // 5: pop and completion in the same cycle.
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        send_word(8'h11, 0);
        check("t5_q_a", q_msb, 8'h11);
        w = 8'h22;
        for (int i = 7; i >= 1; i--) step(w[i], 1, 0, 0);
        check("t5_q_hold", q_msb, 8'h11);
        step(w[0], 1, 0, 1);
        check("t5_q", q_msb, 8'h22);
        check("t5_valid", {7'b0, v_msb}, 8'h01);
        check("t5_ovf", {7'b0, o_msb}, 8'h00);

        // 6: reset mid-word with a pending word and overflow.
        send_word(8'h55, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        check("t6_ovf_pre", {7'b0, o_msb}, 8'h01);
        check("t6_valid_pre", {7'b0, v_msb}, 8'h01);
        rst = 1'b1;
        step(1, 1, 0, 1);
        rst = 1'b0;
        check("t6_rst_q", q_msb, 8'h00);
        check("t6_rst_valid", {7'b0, v_msb}, 8'h00);
        check("t6_rst_ovf", {7'b0, o_msb}, 8'h00);
        send_word(8'hC3, 1);
        check("t6_q", q_msb, 8'hC3);
        check("t6_valid", {7'b0, v_msb}, 8'h01);
        check("t6_lsb_q", q_lsb, 8'hC3);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        step(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
